// File: rtl/morse_char_assembler_if.sv
// Symbol-in / character-out bus for morse_char_assembler.
// master: the producer of symbols and consumer of characters.
// slave: the assembler itself.
interface morse_char_assembler_if;
  logic [2:0] ditsdahs;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       dropped;

  modport master (
    output ditsdahs, sym_valid, char_ready,
    input  sym_ready, char_out, char_valid, dropped
  );

  modport slave (
    input  ditsdahs, sym_valid, char_ready,
    output sym_ready, char_out, char_valid, dropped
  );
endinterface

// File: rtl/morse_char_assembler.sv
// Morse character assembler.
// Collects DIT/DAH elements into a letter pattern and decodes it to ASCII
// when a GAP or SPACE arrives. Word spaces become 0x20. Results are queued
// in a small output FIFO with a valid/ready handshake.
// Optional feature: define MORSE_DIGITS_EN to decode digits 0-9 from
// five-element patterns; otherwise every five-element pattern gives '?'.
module morse_char_assembler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_LEN    = 5
) (
  input  logic                    bigclk,
  input  logic                    rst_n,
  morse_char_assembler_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PAT_W = 5;
  localparam int unsigned LEN_W = 3;

  localparam logic [2:0] CODE_DIT   = 3'd1;
  localparam logic [2:0] CODE_DAH   = 3'd2;
  localparam logic [2:0] CODE_GAP   = 3'd3;
  localparam logic [2:0] CODE_SPACE = 3'd4;

  localparam logic [LEN_W-1:0] LEN_SAT    = LEN_W'(MAX_LEN + 1);
  localparam logic [7:0]       ASCII_SP   = 8'h20;
  localparam logic [7:0]       ASCII_QM   = 8'h3F;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_EMIT_SP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               last_space_q, last_space_d;
  logic               sym_ready_q, sym_ready_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         char_out_q, char_out_d;
  logic               char_valid_q, char_valid_d;
  logic               dropped_q, dropped_d;

  logic               sym_fire_c;
  logic               push_c;
  logic [7:0]         push_data_c;
  logic [7:0]         letter_c;
  logic               pop_c;
  logic               full_c;
  logic               push_ok_c;

  // Pattern-to-ASCII lookup; first element received sits at bit len-1, DAH=1.
  function automatic logic [7:0] lookup(input logic [LEN_W-1:0] l,
                                        input logic [PAT_W-1:0] p);
    logic [7:0] c;
    c = ASCII_QM;
    if (l <= LEN_W'(MAX_LEN)) begin
      case (l)
        3'd1: c = p[0] ? "T" : "E";
        3'd2: begin
          case (p[1:0])
            2'b00:   c = "I";
            2'b01:   c = "A";
            2'b10:   c = "N";
            default: c = "M";
          endcase
        end
        3'd3: begin
          case (p[2:0])
            3'b000:  c = "S";
            3'b001:  c = "U";
            3'b010:  c = "R";
            3'b011:  c = "W";
            3'b100:  c = "D";
            3'b101:  c = "K";
            3'b110:  c = "G";
            default: c = "O";
          endcase
        end
        3'd4: begin
          case (p[3:0])
            4'b0000: c = "H";
            4'b0001: c = "V";
            4'b0010: c = "F";
            4'b0100: c = "L";
            4'b0110: c = "P";
            4'b0111: c = "J";
            4'b1000: c = "B";
            4'b1001: c = "X";
            4'b1010: c = "C";
            4'b1011: c = "Y";
            4'b1100: c = "Z";
            4'b1101: c = "Q";
            default: c = ASCII_QM;
          endcase
        end
        3'd5: begin
`ifdef MORSE_DIGITS_EN
          case (p)
            5'b11111: c = "0";
            5'b01111: c = "1";
            5'b00111: c = "2";
            5'b00011: c = "3";
            5'b00001: c = "4";
            5'b00000: c = "5";
            5'b10000: c = "6";
            5'b11000: c = "7";
            5'b11100: c = "8";
            5'b11110: c = "9";
            default:  c = ASCII_QM;
          endcase
`else
          c = ASCII_QM;
`endif
        end
        default: c = ASCII_QM;
      endcase
    end
    return c;
  endfunction

  assign letter_c   = lookup(len_q, pat_q);
  assign sym_fire_c = bus.sym_valid && sym_ready_q;

  // Next-state logic for the letter FSM: pattern capture and push requests.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    last_space_d = last_space_q;
    push_c       = 1'b0;
    push_data_c  = 8'h00;
    case (state_q)
      ST_COLLECT: begin
        if (sym_fire_c) begin
          case (bus.ditsdahs)
            CODE_DIT, CODE_DAH: begin
              pat_d = {pat_q[PAT_W-2:0], (bus.ditsdahs == CODE_DAH)};
              if (len_q != LEN_SAT) begin
                len_d = len_q + LEN_W'(1);
              end
            end
            CODE_GAP: begin
              if (len_q != '0) begin
                push_c       = 1'b1;
                push_data_c  = letter_c;
                pat_d        = '0;
                len_d        = '0;
                last_space_d = 1'b0;
              end
            end
            CODE_SPACE: begin
              if (len_q != '0) begin
                push_c      = 1'b1;
                push_data_c = letter_c;
                state_d     = ST_EMIT_SP;
              end else if (!last_space_q) begin
                push_c       = 1'b1;
                push_data_c  = ASCII_SP;
                last_space_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EMIT_SP: begin
        push_c       = 1'b1;
        push_data_c  = ASCII_SP;
        last_space_d = 1'b1;
        pat_d        = '0;
        len_d        = '0;
        state_d      = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
    sym_ready_d = (state_d == ST_COLLECT);
  end

  // Output FIFO next-state: push/pop arbitration, drop flag, registered head.
  always_comb begin
    pop_c     = bus.char_ready && (count_q != '0);
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    dropped_d = dropped_q || (push_c && full_c && !pop_c);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
    char_valid_d = (count_d != '0);
    // The new head may be the entry being written this very cycle.
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
      char_out_d = push_data_c;
    end else begin
      char_out_d = mem_q[rd_ptr_d];
    end
  end

  // State and output registers.
  always_ff @(posedge bigclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      pat_q        <= '0;
      len_q        <= '0;
      last_space_q <= 1'b0;
      sym_ready_q  <= 1'b1;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      last_space_q <= last_space_d;
      sym_ready_q  <= sym_ready_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.sym_ready  = sym_ready_q;
  assign bus.char_out   = char_out_q;
  assign bus.char_valid = char_valid_q;
  assign bus.dropped    = dropped_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Testbench for morse_char_assembler: string-level Morse model with a
// character queue, checked every cycle, plus directed literal expectations.
module tb_morse_char_assembler;

  localparam logic [2:0] C_DIT   = 3'd1;
  localparam logic [2:0] C_DAH   = 3'd2;
  localparam logic [2:0] C_GAP   = 3'd3;
  localparam logic [2:0] C_SPACE = 3'd4;

`ifdef MORSE_DIGITS_EN
  localparam int EXP_ONE = 'h31;
`else
  localparam int EXP_ONE = 'h3F;
`endif

  logic bigclk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 bigclk = ~bigclk;

  morse_char_assembler_if bus ();

  morse_char_assembler #(.FIFO_DEPTH(4), .MAX_LEN(5)) dut (
    .bigclk (bigclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // Model: elements as a dot/dash string, characters as a bounded queue.
  byte unsigned code_tab[string];
  string        m_elems;
  bit           m_last_space;
  bit           m_emit;
  bit           m_dropped;
  byte unsigned m_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_table();
    code_tab[".-"]   = "A"; code_tab["-..."] = "B"; code_tab["-.-."] = "C";
    code_tab["-.."]  = "D"; code_tab["."]    = "E"; code_tab["..-."] = "F";
    code_tab["--."]  = "G"; code_tab["...."] = "H"; code_tab[".."]   = "I";
    code_tab[".---"] = "J"; code_tab["-.-"]  = "K"; code_tab[".-.."] = "L";
    code_tab["--"]   = "M"; code_tab["-."]   = "N"; code_tab["---"]  = "O";
    code_tab[".--."] = "P"; code_tab["--.-"] = "Q"; code_tab[".-."]  = "R";
    code_tab["..."]  = "S"; code_tab["-"]    = "T"; code_tab["..-"]  = "U";
    code_tab["...-"] = "V"; code_tab[".--"]  = "W"; code_tab["-..-"] = "X";
    code_tab["-.--"] = "Y"; code_tab["--.."] = "Z";
`ifdef MORSE_DIGITS_EN
    code_tab["-----"] = "0"; code_tab[".----"] = "1"; code_tab["..---"] = "2";
    code_tab["...--"] = "3"; code_tab["....-"] = "4"; code_tab["....."] = "5";
    code_tab["-...."] = "6"; code_tab["--..."] = "7"; code_tab["---.."] = "8";
    code_tab["----."] = "9";
`endif
  endtask

  function automatic byte unsigned decode(input string e);
    if (e.len() > 5) return 8'h3F;
    if (code_tab.exists(e)) return code_tab[e];
    return 8'h3F;
  endfunction

  task automatic model_reset();
    m_elems      = "";
    m_last_space = 1'b0;
    m_emit       = 1'b0;
    m_dropped    = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit sv, input logic [2:0] code, input bit cr);
    bit           pop;
    bit           push;
    bit           was_full;
    byte unsigned pc;
    byte unsigned junk;
    pop      = cr && (m_q.size() != 0);
    was_full = (m_q.size() == 4);
    push     = 1'b0;
    pc       = 8'h00;
    if (m_emit) begin
      push = 1'b1; pc = " "; m_last_space = 1'b1; m_elems = ""; m_emit = 1'b0;
    end else if (sv) begin
      case (code)
        C_DIT: m_elems = {m_elems, "."};
        C_DAH: m_elems = {m_elems, "-"};
        C_GAP: if (m_elems.len() > 0) begin
          push = 1'b1; pc = decode(m_elems); m_elems = ""; m_last_space = 1'b0;
        end
        C_SPACE: if (m_elems.len() > 0) begin
          push = 1'b1; pc = decode(m_elems); m_emit = 1'b1;
        end else if (!m_last_space) begin
          push = 1'b1; pc = " "; m_last_space = 1'b1;
        end
        default: ;
      endcase
    end
    if (pop) junk = m_q.pop_front();
    if (push) begin
      if (was_full && !pop) m_dropped = 1'b1;
      else m_q.push_back(pc);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    bit         s_valid;
    logic [2:0] s_code;
    bit         s_cready;
    forever begin
      @(posedge bigclk);
      s_valid  = bus.sym_valid;
      s_code   = bus.ditsdahs;
      s_cready = bus.char_ready;
      if (!rst_n) model_reset();
      else model_step(s_valid, s_code, s_cready);
      #1;
      chk("char_valid", int'(bus.char_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) chk("char_out", int'(bus.char_out), int'(m_q[0]));
      chk("sym_ready", int'(bus.sym_ready), int'(!m_emit));
      chk("dropped", int'(bus.dropped), int'(m_dropped));
    end
  end

  task automatic send(input logic [2:0] c);
    int n;
    @(negedge bigclk);
    bus.sym_valid = 1'b1;
    bus.ditsdahs  = c;
    n = 0;
    while (!bus.sym_ready && n < 8) begin
      @(negedge bigclk);
      n++;
    end
    if (!bus.sym_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sym_ready got 0 expected 1 at %0t", $time);
    end
    @(posedge bigclk);
    #1;
    bus.sym_valid = 1'b0;
    bus.ditsdahs  = 3'd0;
  endtask

  // '.' DIT, '-' DAH, 'g' GAP, ' ' SPACE
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "." : send(C_DIT);
        "-" : send(C_DAH);
        "g" : send(C_GAP);
        default: send(C_SPACE);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_table();
    model_reset();
    rst_n          = 1'b0;
    bus.sym_valid  = 1'b0;
    bus.ditsdahs   = 3'd0;
    bus.char_ready = 1'b0;
    repeat (2) @(posedge bigclk);
    #1;
    chk("rst_char_out", int'(bus.char_out), 'h00);
    chk("rst_char_valid", int'(bus.char_valid), 0);
    chk("rst_sym_ready", int'(bus.sym_ready), 1);
    chk("rst_dropped", int'(bus.dropped), 0);
    @(negedge bigclk);
    rst_n          = 1'b1;
    bus.char_ready = 1'b1;

    // A: valid for exactly one cycle after the GAP edge
    send_str(".-g");
    chk("a_valid", int'(bus.char_valid), 1);
    chk("a_char", int'(bus.char_out), 'h41);
    @(posedge bigclk); #1;
    chk("a_valid_fall", int'(bus.char_valid), 0);

    // Q then word space on consecutive cycles, one-cycle sym_ready bubble
    send_str("--.- ");
    chk("q_char", int'(bus.char_out), 'h51);
    chk("q_sym_ready_low", int'(bus.sym_ready), 0);
    @(posedge bigclk); #1;
    chk("q_space", int'(bus.char_out), 'h20);
    chk("q_space_valid", int'(bus.char_valid), 1);
    chk("q_sym_ready_back", int'(bus.sym_ready), 1);
    @(posedge bigclk); #1;
    chk("q_drained", int'(bus.char_valid), 0);

    // Over-length letter, then repeated spaces collapse to one
    send_str("......g");
    chk("long_char", int'(bus.char_out), 'h3F);
    send_str(" ");
    chk("sp1_char", int'(bus.char_out), 'h20);
    chk("sp1_valid", int'(bus.char_valid), 1);
    send_str("  ");
    chk("sp3_valid", int'(bus.char_valid), 0);

    // Back-pressure: four E's queue, fifth is dropped
    bus.char_ready = 1'b0;
    send_str(".g.g.g.g.g");
    chk("full_dropped", int'(bus.dropped), 1);
    chk("full_head", int'(bus.char_out), 'h45);
    @(posedge bigclk); #1;
    chk("full_head_stable", int'(bus.char_out), 'h45);
    bus.char_ready = 1'b1;
    repeat (4) @(posedge bigclk);
    #1;
    chk("drain_valid", int'(bus.char_valid), 0);
    chk("drain_dropped_held", int'(bus.dropped), 1);

    // Five-element pattern
    send_str(".----g");
    chk("digit_one", int'(bus.char_out), EXP_ONE);

    // Reset with a partial letter and two queued characters
    bus.char_ready = 1'b0;
    send_str(".g.g.-");
    chk("pre_rst_valid", int'(bus.char_valid), 1);
    @(negedge bigclk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.char_valid), 0);
    chk("mid_rst_dropped", int'(bus.dropped), 0);
    chk("mid_rst_sym_ready", int'(bus.sym_ready), 1);
    @(negedge bigclk);
    rst_n          = 1'b1;
    bus.char_ready = 1'b1;
    send_str(".g");
    chk("post_rst_char", int'(bus.char_out), 'h45);
    chk("post_rst_valid", int'(bus.char_valid), 1);

    repeat (3) @(posedge bigclk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
